// File: rtl/mips_pkg.sv
// Shared definitions for the decode-stage forwarding / hazard logic: register
// index width, the zero-register index, forwarding select codes and stage records.
package mips_pkg;

    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_QA    = 2'b00;
    localparam logic [1:0] FWD_EXE   = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;
    localparam logic [1:0] FWD_MEMLD = 2'b11;

    // Destination-register information carried by the shadow pipeline.
    typedef struct packed {
        logic [REG_W-1:0] rn;
        logic             wreg;
        logic             m2reg;
    } stage_info_t;

    localparam stage_info_t STAGE_NOP = '{rn: REG_ZERO, wreg: 1'b0, m2reg: 1'b0};

endpackage

// File: rtl/fwd_sel_logic.sv
// Combinational forwarding select for one decode-stage operand.
// The younger EXE result is checked first so it wins over an older MEM write.
module fwd_sel_logic
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  stage_info_t      e_info,
    input  stage_info_t      m_info,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_QA;
        if (use_src && (src != REG_ZERO)) begin
            if (e_info.wreg && (e_info.rn == src) && !e_info.m2reg) begin
                sel = FWD_EXE;
            end else if (m_info.wreg && (m_info.rn == src)) begin
                sel = m_info.m2reg ? FWD_MEMLD : FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall unit with an EXE/MEM shadow pipeline.
// Optional statistics counters are enabled with FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_W = mips_pkg::REG_W,
    parameter int NREGS = mips_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic             bubble,
`ifdef FWD_HAZARD_STATS_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt,
`endif
    output logic [REG_W-1:0] e_rn_o,
    output logic [REG_W-1:0] m_rn_o
);

    // The stage records are sized by the package, so the overrides must agree.
    if (REG_W != mips_pkg::REG_W || NREGS != (1 << REG_W)) begin : g_param_check
        $error("fwd_hazard_unit: REG_W/NREGS inconsistent with mips_pkg");
    end

    stage_info_t id_info;
    stage_info_t e_info;
    stage_info_t m_info;

    assign id_info = '{rn: id_rn, wreg: id_wreg, m2reg: id_m2reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_info <= STAGE_NOP;
            m_info <= STAGE_NOP;
        end else begin
            m_info <= e_info;
            e_info <= stall ? STAGE_NOP : id_info;
        end
    end

    fwd_sel_logic u_sel_a (
        .src     (id_rs),
        .use_src (id_use_rs),
        .e_info  (e_info),
        .m_info  (m_info),
        .sel     (fwda)
    );

    fwd_sel_logic u_sel_b (
        .src     (id_rt),
        .use_src (id_use_rt),
        .e_info  (e_info),
        .m_info  (m_info),
        .sel     (fwdb)
    );

    // A load in EXE cannot supply its data yet; hold ID one cycle so it reaches MEM.
    assign stall = e_info.wreg & e_info.m2reg & (e_info.rn != REG_ZERO) &
                   ((id_use_rs & (e_info.rn == id_rs)) |
                    (id_use_rt & (e_info.rn == id_rt)));
    assign bubble = stall;

    assign e_rn_o = e_info.rn;
    assign m_rn_o = m_info.rn;

`ifdef FWD_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (((fwda != FWD_QA) || (fwdb != FWD_QA)) && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed ID-stage vectors push expected
// selects/stall/shadow values; a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic [1:0] fwda, fwdb;
    logic       stall, bubble;
    logic [4:0] e_rn_o, m_rn_o;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic [4:0] ern;
        logic [4:0] mrn;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_sc = 0;
    int   model_fc = 0;

    fwd_hazard_unit dut (
        .clk       (clk),
        .rst       (rst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_rn     (id_rn),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall     (stall),
        .bubble    (bubble),
`ifdef FWD_HAZARD_STATS_EN
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt),
`endif
        .e_rn_o    (e_rn_o),
        .m_rn_o    (m_rn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string fld, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, fld, act, expv);
        end
    endtask

    // Monitor: the unit is combinational per cycle, so every cycle with a pending
    // expectation is a presented response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "fwda",   int'(fwda),   int'(e.fa));
            cmp(e.name, "fwdb",   int'(fwdb),   int'(e.fb));
            cmp(e.name, "stall",  int'(stall),  int'(e.st));
            cmp(e.name, "bubble", int'(bubble), int'(e.st));
            cmp(e.name, "e_rn",   int'(e_rn_o), int'(e.ern));
            cmp(e.name, "m_rn",   int'(m_rn_o), int'(e.mrn));
`ifdef FWD_HAZARD_STATS_EN
            cmp(e.name, "stall_cnt", int'(stall_cnt), e.sc);
            cmp(e.name, "fwd_cnt",   int'(fwd_cnt),   e.fc);
`endif
            $display("txn %-10s fwda=%0d fwdb=%0d stall=%0d e_rn=%0d m_rn=%0d",
                     e.name, fwda, fwdb, stall, e_rn_o, m_rn_o);
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rn, input logic wreg,
                         input logic m2);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rn = rn; id_wreg = wreg; id_m2reg = m2;
    endtask

    task automatic push_exp(input string name, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic [4:0] ern, input logic [4:0] mrn);
        exp_t e;
        e.name = name; e.fa = fa; e.fb = fb; e.st = st; e.ern = ern; e.mrn = mrn;
        e.sc = model_sc; e.fc = model_fc;
        exp_q.push_back(e);
        model_sc += int'(st);
        model_fc += int'((fa != 2'b00) || (fb != 2'b00));
    endtask

    // One ID-stage cycle: drive after the edge, expect results in this same cycle.
    task automatic step(input string name, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rn,
                        input logic wreg, input logic m2, input logic [1:0] fa,
                        input logic [1:0] fb, input logic st, input logic [4:0] ern,
                        input logic [4:0] mrn);
        @(posedge clk);
        #1;
        drive(rs, rt, urs, urt, rn, wreg, m2);
        push_exp(name, fa, fb, st, ern, mrn);
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //    name          rs  rt  urs urt rn  wr  m2   fa     fb     st  ern  mrn
        step("nop",         0,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,   0);
        step("add_r3",      1,  2,  1,  1,  3,  1,  0,  2'b00, 2'b00, 0,  0,   0);
        step("exe_fwd",     3,  4,  1,  1,  6,  1,  0,  2'b01, 2'b00, 0,  3,   0);
        step("mem_fwd",     3,  8,  1,  1, 10,  1,  0,  2'b10, 2'b00, 0,  6,   3);
        step("lw_r5",       1,  0,  1,  0,  5,  1,  1,  2'b00, 2'b00, 0, 10,   6);
        step("lu_stall",    2,  5,  1,  1, 11,  1,  0,  2'b00, 2'b00, 1,  5,  10);
        step("lu_resolve",  2,  5,  1,  1, 11,  1,  0,  2'b00, 2'b11, 0,  0,   5);
        step("wr_r7_a",     1,  0,  1,  0,  7,  1,  0,  2'b00, 2'b00, 0, 11,   0);
        step("wr_r7_b",     0,  0,  0,  0,  7,  1,  0,  2'b00, 2'b00, 0,  7,  11);
        step("prio_exe",    7,  7,  1,  1, 12,  1,  0,  2'b01, 2'b01, 0,  7,   7);
        step("lw_r0",       1,  0,  1,  0,  0,  1,  1,  2'b00, 2'b00, 0, 12,   7);
        step("zero_ld",     0,  0,  1,  1, 13,  1,  0,  2'b00, 2'b00, 0,  0,  12);
        step("add_r0",      0,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 0, 13,   0);
        step("zero_alu",    0,  0,  1,  1, 14,  1,  0,  2'b00, 2'b00, 0,  0,  13);
        step("lw_r5_a",     1,  0,  1,  0,  5,  1,  1,  2'b00, 2'b00, 0, 14,   0);
        step("b2b_st1",     5,  0,  1,  0,  5,  1,  1,  2'b00, 2'b00, 1,  5,  14);
        step("b2b_res1",    5,  0,  1,  0,  5,  1,  1,  2'b11, 2'b00, 0,  0,   5);
        step("b2b_st2",     5,  0,  1,  0, 15,  1,  0,  2'b00, 2'b00, 1,  5,   0);
        step("b2b_res2",    5,  0,  1,  0, 15,  1,  0,  2'b11, 2'b00, 0,  0,   5);
        step("lw_r9",       0,  0,  0,  0,  9,  1,  1,  2'b00, 2'b00, 0, 15,   0);

        // Mid-cycle async reset while a load-use stall is pending on r9.
        @(posedge clk);
        #1 drive(5'd9, 5'd9, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_sc = 0;
        model_fc = 0;
        push_exp("rst_mid", 2'b00, 2'b00, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        step("post_rst",    0,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,   0);
        step("post_rst2",   3,  3,  1,  1,  0,  0,  0,  2'b00, 2'b00, 0,  0,   0);

        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
